// File: rtl/port_pg_sequencer_pkg.sv
// Shared power-gating encodings, port types and default timing.
// Imported by the per-port FSM and the 4-port sequencer top.
package port_pg_sequencer_pkg;

  typedef enum logic [1:0] {
    PG_ACTIVE = 2'd0,
    PG_DRAIN  = 2'd1,
    PG_SLEEP  = 2'd2,
    PG_WAKE   = 2'd3
  } pg_state_t;

  typedef enum logic {
    NONPERMANENT = 1'b0,
    PERMANENT    = 1'b1
  } pg_type_t;

  typedef struct packed {
    logic power;
    logic ready;
  } pg_out_t;

  localparam int PG_PORTS     = 4;
  localparam int PG_IDLE_TH   = 8;
  localparam int PG_DRAIN_CYC = 2;
  localparam int PG_WAKE_LAT  = 4;
  localparam int PG_CNT_W     = 4;

  // Power stays on everywhere except SLEEP; only ACTIVE is allocatable.
  function automatic pg_out_t pg_decode(pg_state_t s);
    pg_out_t o;
    o.power = (s != PG_SLEEP);
    o.ready = (s == PG_ACTIVE);
    return o;
  endfunction

endpackage

// File: rtl/port_pg_sequencer_fsm.sv
// One port's power-gating FSM: state, phase counter, optional sleep stat.
// The sleep statistic counter exists only when PG_STATS_EN is defined.
module port_pg_fsm
  import port_pg_sequencer_pkg::*;
#(
  parameter int IDLE_TH   = PG_IDLE_TH,
  parameter int DRAIN_CYC = PG_DRAIN_CYC,
  parameter int WAKE_LAT  = PG_WAKE_LAT,
  parameter int CNT_W     = PG_CNT_W
`ifdef PG_STATS_EN
  ,
  parameter int STAT_W    = 16
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic gate,
  input  logic idle,
  input  logic wake,
  output logic power,
  output logic ready
`ifdef PG_STATS_EN
  ,
  output logic [STAT_W-1:0] sleep_count
`endif
);

  localparam logic [CNT_W-1:0] IDLE_LAST =
    CNT_W'(IDLE_TH - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST =
    CNT_W'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST =
    CNT_W'(WAKE_LAT - 1);

  pg_state_t state;
  pg_state_t state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic qual;
  pg_out_t out_nxt;

  assign qual    = gate & idle & ~wake;
  assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
  assign out_nxt = pg_decode(state_nxt);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      PG_ACTIVE: begin
        if (!qual) begin
          cnt_nxt = '0;
        end else if (cnt >= IDLE_LAST) begin
          state_nxt = PG_DRAIN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      PG_DRAIN: begin
        // Any sign of traffic or loss of gating aborts before power drops.
        if (!qual) begin
          state_nxt = PG_ACTIVE;
          cnt_nxt   = '0;
        end else if (cnt >= DRAIN_LAST) begin
          state_nxt = PG_SLEEP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      PG_SLEEP: begin
        if (wake | ~gate) begin
          state_nxt = PG_WAKE;
          cnt_nxt   = '0;
        end
      end
      PG_WAKE: begin
        if (cnt >= WAKE_LAST) begin
          state_nxt = PG_ACTIVE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = PG_ACTIVE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= PG_ACTIVE;
      cnt   <= '0;
      power <= 1'b1;
      ready <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      power <= out_nxt.power;
      ready <= out_nxt.ready;
    end
  end

`ifdef PG_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      sleep_count <= '0;
    end else if (state == PG_SLEEP && !(&sleep_count)) begin
      sleep_count <= sleep_count + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/port_pg_sequencer.sv
// 4-port power-gating sequencer (S,N,W,E = bits 3..0).
// Optional per-port sleep statistics when PG_STATS_EN is defined.
module port_pg_sequencer
  import port_pg_sequencer_pkg::*;
#(
  parameter int IDLE_TH   = PG_IDLE_TH,
  parameter int DRAIN_CYC = PG_DRAIN_CYC,
  parameter int WAKE_LAT  = PG_WAKE_LAT,
  parameter int CNT_W     = PG_CNT_W
`ifdef PG_STATS_EN
  ,
  parameter int STAT_W    = 16
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pgEnable,
  input  logic [3:0] portPGTypeVector,
  input  logic [3:0] portIdle,
  input  logic [3:0] wakeReq,
  output logic [3:0] portPowerOn,
  output logic [3:0] portReady
`ifdef PG_STATS_EN
  ,
  output logic [PG_PORTS*STAT_W-1:0] sleepCycleCount
`endif
);

  logic [PG_PORTS-1:0] gate;

  for (genvar p = 0; p < PG_PORTS; p++) begin : g_port
    // PERMANENT ports are never gated regardless of the global enable.
    assign gate[p] = pgEnable &
      (portPGTypeVector[p] != PERMANENT);

    port_pg_fsm #(
      .IDLE_TH   (IDLE_TH),
      .DRAIN_CYC (DRAIN_CYC),
      .WAKE_LAT  (WAKE_LAT),
      .CNT_W     (CNT_W)
`ifdef PG_STATS_EN
      ,
      .STAT_W    (STAT_W)
`endif
    ) u_fsm (
      .clk   (clk),
      .reset (reset),
      .gate  (gate[p]),
      .idle  (portIdle[p]),
      .wake  (wakeReq[p]),
      .power (portPowerOn[p]),
      .ready (portReady[p])
`ifdef PG_STATS_EN
      ,
      .sleep_count
        (sleepCycleCount[p*STAT_W +: STAT_W])
`endif
    );
  end

endmodule

// File: tb/tb_port_pg_sequencer.sv
// Self-checking bench for port_pg_sequencer: vector table, corner
// sequences and randomized traffic against a behavioural model.
module tb_port_pg_sequencer;

  localparam int IDLE_TH   = 8;
  localparam int DRAIN_CYC = 2;
  localparam int WAKE_LAT  = 4;
  localparam int STAT_W    = 16;
  localparam longint STAT_MAX = (64'd1 << STAT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       pgEnable;
  logic [3:0] typ;
  logic [3:0] idle;
  logic [3:0] wake;
  logic [3:0] power;
  logic [3:0] ready;
`ifdef PG_STATS_EN
  logic [4*STAT_W-1:0] stats;
`endif

  port_pg_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .pgEnable         (pgEnable),
    .portPGTypeVector (typ),
    .portIdle         (idle),
    .wakeReq          (wake),
    .portPowerOn      (power),
    .portReady        (ready)
`ifdef PG_STATS_EN
    ,
    .sleepCycleCount  (stats)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t",
               name, act, exp, $time);
    end
  endtask

  // Model: each port is "awake", "draining", "asleep" or "waking",
  // with the number of cycles spent in the current phase.
  typedef enum int {AWAKE, DRAINING, ASLEEP, WAKING} phase_t;
  phase_t m_ph[4];
  int     m_run[4];
  int     m_el[4];
  longint m_stat[4];

  initial begin
    for (int p = 0; p < 4; p++) begin
      m_ph[p] = AWAKE; m_run[p] = 0;
      m_el[p] = 0; m_stat[p] = 0;
    end
  end

  function automatic void model_edge();
    bit g, q;
    for (int p = 0; p < 4; p++) begin
      if (!reset) begin
        m_ph[p] = AWAKE; m_run[p] = 0;
        m_el[p] = 0; m_stat[p] = 0;
        continue;
      end
      g = pgEnable && !typ[p];
      q = g && idle[p] && !wake[p];
      if (m_ph[p] == ASLEEP && m_stat[p] < STAT_MAX)
        m_stat[p]++;
      case (m_ph[p])
        AWAKE: begin
          m_run[p] = q ? m_run[p] + 1 : 0;
          if (m_run[p] == IDLE_TH) begin
            m_ph[p] = DRAINING; m_el[p] = 0; m_run[p] = 0;
          end
        end
        DRAINING: begin
          if (!q) begin
            m_ph[p] = AWAKE; m_run[p] = 0;
          end else begin
            m_el[p]++;
            if (m_el[p] == DRAIN_CYC) m_ph[p] = ASLEEP;
          end
        end
        ASLEEP: begin
          if (wake[p] || !g) begin
            m_ph[p] = WAKING; m_el[p] = 0;
          end
        end
        default: begin
          m_el[p]++;
          if (m_el[p] == WAKE_LAT) begin
            m_ph[p] = AWAKE; m_run[p] = 0;
          end
        end
      endcase
    end
  endfunction

  function automatic logic [3:0] m_power();
    logic [3:0] v;
    for (int p = 0; p < 4; p++) v[p] = (m_ph[p] != ASLEEP);
    return v;
  endfunction

  function automatic logic [3:0] m_ready();
    logic [3:0] v;
    for (int p = 0; p < 4; p++) v[p] = (m_ph[p] == AWAKE);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model(string tag);
    chk({tag, "_power"}, 64'(power), 64'(m_power()));
    chk({tag, "_ready"}, 64'(ready), 64'(m_ready()));
`ifdef PG_STATS_EN
    for (int p = 0; p < 4; p++)
      chk({tag, "_stat"}, 64'(stats[p*STAT_W +: STAT_W]),
          64'(m_stat[p]));
`endif
  endtask

  task automatic drive(logic r, logic en, logic [3:0] t,
                       logic [3:0] i, logic [3:0] w);
    reset = r; pgEnable = en; typ = t; idle = i; wake = w;
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] t;
    logic [3:0] i;
    logic [3:0] w;
    logic [3:0] exp_power;
    logic [3:0] exp_ready;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic r, logic en, logic [3:0] t,
                              logic [3:0] i, logic [3:0] w,
                              logic [3:0] ep, logic [3:0] er);
    vec_t v;
    v.rst = r; v.en = en; v.t = t; v.i = i; v.w = w;
    v.exp_power = ep; v.exp_ready = er;
    return v;
  endfunction

  initial begin
    drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);

    // Reset, gate W/E to sleep, then wake E with a one-cycle pulse.
    for (int k = 0; k < 3; k++)
      vt.push_back(mk(0, 0, 0, 0, 0, 4'hF, 4'hF));
    for (int k = 1; k <= 10; k++)
      vt.push_back(mk(1, 1, 4'hC, 4'hF, 4'h0,
                      (k >= 10) ? 4'hC : 4'hF,
                      (k >= 8) ? 4'hC : 4'hF));
    vt.push_back(mk(1, 1, 4'hC, 4'hF, 4'h1, 4'hD, 4'hC));
    for (int k = 2; k <= 5; k++)
      vt.push_back(mk(1, 1, 4'hC, 4'hF, 4'h0, 4'hD,
                      (k == 5) ? 4'hD : 4'hC));

    foreach (vt[k]) begin
      if (!vt[k].rst)
        drive(1'b0, 1'($urandom), 4'($urandom),
              4'($urandom), 4'($urandom));
      else
        drive(1'b1, vt[k].en, vt[k].t, vt[k].i, vt[k].w);
      step();
      chk($sformatf("vec%0d_power", k), 64'(power),
          64'(vt[k].exp_power));
      chk($sformatf("vec%0d_ready", k), 64'(ready),
          64'(vt[k].exp_ready));
`ifdef PG_STATS_EN
      if (!vt[k].rst)
        chk("reset_stats", 64'(stats), 64'd0);
`endif
    end

    // Drain abort on E, then idle count must restart from zero.
    drive(0, 0, 0, 0, 0);
    step();
    drive(1, 1, 4'hC, 4'hF, 4'h0);
    for (int k = 0; k < IDLE_TH; k++) step();
    chk("abort_pre_ready", 64'(ready), 64'hC);
    idle = 4'hE;
    step();
    chk("abort_ready", 64'(ready), 64'hD);
    chk("abort_power", 64'(power), 64'hF);
    idle = 4'hF;
    for (int k = 1; k < IDLE_TH; k++) begin
      step();
      chk("abort_e_ready", 64'(ready[0]), 64'd1);
      chk("abort_e_power", 64'(power[0]), 64'd1);
    end
    step();
    chk("abort_redrain", 64'(ready[0]), 64'd0);
    for (int k = 0; k < DRAIN_CYC; k++) step();
    chk("both_sleep", 64'(power), 64'hC);

    // Dropping the global enable wakes both gated ports.
    pgEnable = 1'b0;
    step();
    chk("ovr_power", 64'(power), 64'hF);
    for (int k = 1; k < WAKE_LAT; k++) begin
      step();
      chk("ovr_ready_wait", 64'(ready), 64'hC);
    end
    step();
    chk("ovr_ready", 64'(ready), 64'hF);
    check_model("ovr");

`ifdef PG_STATS_EN
    // E sleeps exactly 20 cycles before the wake is sampled.
    drive(0, 0, 0, 0, 0);
    step();
    drive(1, 1, 4'hE, 4'hF, 4'h0);
    for (int k = 0; k < IDLE_TH + DRAIN_CYC; k++) step();
    for (int k = 0; k < 19; k++) step();
    wake = 4'h1;
    step();
    wake = 4'h0;
    for (int k = 0; k < 3; k++) step();
    chk("stat_e", 64'(stats[STAT_W-1:0]),
        (STAT_MAX < 20) ? 64'(STAT_MAX) : 64'd20);
    chk("stat_other", 64'(stats[4*STAT_W-1:STAT_W]), 64'd0);
`endif

    // Randomized traffic against the model.
    drive(0, 0, 0, 0, 0);
    step();
    typ = 4'($urandom);
    for (int n = 0; n < 3000; n++) begin
      reset    = ($urandom_range(0, 299) != 0);
      pgEnable = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 59) == 0) typ = 4'($urandom);
      for (int p = 0; p < 4; p++) begin
        idle[p] = ($urandom_range(0, 15) != 0);
        wake[p] = ($urandom_range(0, 19) == 0);
      end
      step();
      check_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
